// File: rtl/ram_port_pkg.sv
// ram_port_pkg
// Shared definitions for the 64x8 dual-port RAM port initiator: default
// address/data widths and the port sequencer state encoding. The RAM model
// and the bench reuse these so everyone agrees on widths and state names.
package ram_port_pkg;

    localparam int unsigned RAM_ADDR_W = 6;
    localparam int unsigned RAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } port_state_t;

endpackage

// File: rtl/ram_port_master.sv
// ram_port_master
// Synchronous initiator for one port of the asynchronous dual-port RAM.
// Accepts single-word read/write requests, sequences the RAM's level-sensitive
// pins with address setup, strobe, hold and bus turnaround, and returns a
// one-cycle completion carrying read data.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake
//   req_write/addr/wdata  request fields (1 = write)
//   rsp_valid, rsp_rdata  completion pulse and read data
//   ram_addr/we/re        RAM control pins, all driven straight from flops
//   ram_data              shared data bus, driven only during writes
module ram_port_master
    import ram_port_pkg::*;
#(
    parameter int unsigned ADDR_W    = RAM_ADDR_W,
    parameter int unsigned DATA_W    = RAM_DATA_W,
    parameter int unsigned WR_CYCLES = 1,
    parameter int unsigned RD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    inout  logic [DATA_W-1:0] ram_data
);

    if (WR_CYCLES < 1 || WR_CYCLES > 15) begin : g_bad_wr_cycles
        $error("ram_port_master: WR_CYCLES must be in 1..15");
    end
    if (RD_CYCLES < 1 || RD_CYCLES > 15) begin : g_bad_rd_cycles
        $error("ram_port_master: RD_CYCLES must be in 1..15");
    end

    // Strobe counter is loaded with N-1 and the last strobe cycle sees zero.
    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

    port_state_t       state_q, state_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              drv_q, drv_d;
    logic [ADDR_W-1:0] addr_d;
    logic              we_d, re_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rdata_d;

    assign req_ready = (state_q == IDLE);
    assign ram_data  = drv_q ? wdata_q : 'z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            drv_q     <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            drv_q     <= drv_d;
            ram_addr  <= addr_d;
            ram_we    <= we_d;
            ram_re    <= re_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rdata_d;
        end
    end

    // Next-state logic computes the values every RAM-facing flop takes on the
    // following edge, so the pins change only at clock edges.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        drv_d       = drv_q;
        addr_d      = ram_addr;
        we_d        = 1'b0;
        re_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rdata_d     = rsp_rdata;

        unique case (state_q)
            IDLE: begin
                drv_d = 1'b0;
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    drv_d   = req_write;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = wr_q ? WR_LOAD : RD_LOAD;
                we_d    = wr_q;
                re_d    = !wr_q;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d     = HOLD;
                    rsp_valid_d = 1'b1;
                    if (!wr_q) begin
                        rdata_d = ram_data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    we_d  = wr_q;
                    re_d  = !wr_q;
                end
            end
            HOLD: begin
                // Write data stays driven through HOLD and is released here.
                drv_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/ram_port_master.md
# ram_port_master

Synchronous initiator for one port of the team's 64x8 asynchronous dual-port RAM with shared bidirectional data. It accepts single-word read/write requests on a valid/ready interface. It sequences the RAM's level-sensitive address, write-enable, read-enable and tri-state data pins with address setup, hold and bus-turnaround guarantees. It returns a completion, carrying read data, to the requesting logic. One instance sits in front of each RAM port.

## Interface
- ADDR_W, 6, RAM address width
- DATA_W, 8, RAM data width
- WR_CYCLES, 1, cycles ram_we is held high per write; legal range 1..15, elaboration error otherwise
- RD_CYCLES, 1, cycles ram_re is held high before read data is sampled; legal range 1..15
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  target word
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  one-cycle completion pulse, for both reads and writes; no backpressure
- rsp_rdata  output  DATA_W  read data; valid with rsp_valid after a read
- ram_addr  output  ADDR_W  RAM port address
- ram_we  output  1  RAM port write enable
- ram_re  output  1  RAM port read enable
- ram_data  inout  DATA_W  RAM port data; driven by this block only during writes

## Operation
- The FSM has four states: IDLE, SETUP, STROBE and HOLD.
  - IDLE: req_ready=1. On req_valid&&req_ready, capture write/addr/wdata into registers, then go to SETUP.
  - SETUP: one cycle. ram_addr takes the captured address. ram_we and ram_re are 0. A write enables the data driver with the captured wdata.
  - STROBE: lasts WR_CYCLES cycles for a write or RD_CYCLES cycles for a read; a 4-bit down-counter is loaded on entry. A write asserts ram_we=1 with data driven. A read asserts ram_re=1 with the bus released. On the final STROBE edge of a read, ram_data is captured into rsp_rdata.
  - HOLD: one cycle. ram_we and ram_re are 0, ram_addr is unchanged, and write data is still driven. rsp_valid=1. Next state is IDLE.
- req_ready=0 in SETUP, STROBE and HOLD. Requests are never queued.
- ram_addr, ram_we, ram_re and the data-drive enable come straight from flops, so the level-sensitive RAM sees no glitches.
- The block never drives ram_data while ram_re=1. After a read, ram_re is low for at least 2 cycles before any write drive begins.
- ram_addr holds its last value in IDLE. rsp_rdata holds its value until the next read completes, and writes leave it unchanged.
- Address arithmetic: none. Addresses pass through unchanged, and 0 and 2^ADDR_W-1 are ordinary words.

## Timing
- E0 is the rising edge on which req_valid&&req_ready holds. Cycle k is the cycle after edge Ek.
- Write: SETUP in cycle 1, STROBE in cycles 2..1+WR_CYCLES, HOLD/rsp_valid in cycle 2+WR_CYCLES, req_ready=1 in cycle 3+WR_CYCLES.
- Read: same sequence with RD_CYCLES. rsp_rdata is valid in the HOLD cycle.
- Throughput is one transaction per 3+N cycles.
- Reset values, applied immediately on rst_n falling:
  - state=IDLE, req_ready=1
  - rsp_valid=0, rsp_rdata=0
  - ram_addr=0, ram_we=0, ram_re=0
  - ram_data high-Z
- Handshakes are ignored while rst_n=0.
- Reset mid-transaction: the transaction is dropped and no rsp_valid is issued. A partially strobed write leaves that RAM word undefined.
- req_valid may drop without a handshake; nothing is captured.

## Structure
- Shared package/header ram_port_pkg holds the state encodings (IDLE, SETUP, STROBE, HOLD) and the default ADDR_W/DATA_W, because the RAM model and the bench reuse them.
- No sub-module. The tri-state assignment, FSM, strobe counter and capture registers all sit in ram_port_master.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with req_valid=1 -> ram_we=ram_re=0, ram_data=Z, ram_addr=0, rsp_valid=0, no capture.
- **Write (WR_CYCLES=1):** write 0xA5 to 0x12 -> cycle 1: ram_addr=0x12, data=0xA5, ram_we=0. Cycle 2: ram_we=1. Cycle 3: ram_we=0, data still 0xA5, rsp_valid=1. Cycle 4: req_ready=1. RAM model mem[0x12]=0xA5.
- **Read (RD_CYCLES=2):** read 0x12 -> ram_re=1 in cycles 2-3. The master never drives while ram_re=1. rsp_valid=1 with rsp_rdata=0xA5 in cycle 4.
- **Back-to-back read then write:** hold req_valid high -> req_ready=0 from SETUP to HOLD. At least 2 cycles between ram_re falling and the write drive. No X or contention on ram_data.
- **Reset mid-write:** assert rst_n=0 in the write STROBE cycle -> ram_we=0 and ram_data=Z asynchronously, no rsp_valid. req_ready=1 after release.
- **Boundary addresses:** write 0x11 to 0x3F and 0x22 to 0x00, then read both back -> 0x11 and 0x22 respectively.
